// File: rtl/neo_lb_pkg.sv
// neo_lb_pkg: shared types and constants for the line-buffer readout path.
package neo_lb_pkg;

  // Reader sequencing: wait for a line, prime the RAM address, stream pixels.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_ACTIVE = 2'd2
  } lb_state_t;

  // Palette index shown when no line pixel is being emitted.
  localparam logic [11:0] BACKDROP = 12'hFFF;

  // Visible pixels per line in the standard video mode.
  localparam int DEFAULT_LINE_LEN = 320;

endpackage

// File: rtl/lb_rd_ctr.sv
// lb_rd_ctr: line-buffer read address plus pixel counter.
// The address wraps freely at 2^ADDR_W; the counter flags when LINE_LEN
// pixels have been stepped through since the last load.
module lb_rd_ctr
  import neo_lb_pkg::*;
#(
  parameter int LINE_LEN = DEFAULT_LINE_LEN,
  parameter int ADDR_W   = 9
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              i_load,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_base,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_tc
);

  localparam int CNT_W = $clog2(LINE_LEN + 1);

  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;

  // Load restarts both at the line origin; increment advances them together.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      r_addr <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
      r_cnt  <= '0;
    end else if (i_inc) begin
      r_addr <= r_addr + ADDR_W'(1);
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_tc   = (r_cnt == CNT_W'(LINE_LEN));

endmodule

// File: rtl/lb_reader.sv
// lb_reader: streams one line of pixels out of the displayed line-buffer
// bank into the palette address, two pixel ticks after the line start.
// Optional macro LB_READ_CLEAR_EN: write the backdrop value back to each
// address once it has been read, so the buffer is clean for the next fill.
// CE_PIX must not be high on two consecutive CLKs: the RAM needs one CLK
// after each address step before its data is sampled on the next tick.
module lb_reader
  import neo_lb_pkg::*;
#(
  parameter int LINE_LEN = DEFAULT_LINE_LEN,
  parameter int ADDR_W   = 9
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              CE_PIX,
  input  logic              LINE_START,
  input  logic [ADDR_W-1:0] H_OFS,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [11:0]       RD_DATA,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [11:0]       WR_DATA,
  output logic              BANK,
  output logic [11:0]       PAL_ADDR,
  output logic              PAL_VALID,
  output logic              LINE_DONE
);

  lb_state_t         r_state;
  lb_state_t         w_next;
  logic              r_start_pend;
  logic              r_bank;
  logic              r_line_done;
  logic              r_pal_valid;
  logic [11:0]       r_pal;
  logic              w_accept;
  logic              w_load;
  logic              w_inc;
  logic              w_pixel;
  logic              w_finish;
  logic              w_tc;
  logic [ADDR_W-1:0] w_addr;

  // A start seen between pixel ticks is remembered until the next tick.
  assign w_accept = CE_PIX & (LINE_START | r_start_pend);

  lb_rd_ctr #(
    .LINE_LEN (LINE_LEN),
    .ADDR_W   (ADDR_W)
  ) u_ctr (
    .CLK    (CLK),
    .nRESET (nRESET),
    .i_load (w_load),
    .i_inc  (w_inc),
    .i_base (H_OFS),
    .o_addr (w_addr),
    .o_tc   (w_tc)
  );

  // Next state and per-tick actions; a start always wins and restarts the line.
  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_inc    = 1'b0;
    w_pixel  = 1'b0;
    w_finish = 1'b0;
    if (CE_PIX) begin
      unique case (r_state)
        ST_IDLE:   w_next = ST_IDLE;
        ST_FETCH:  w_next = ST_ACTIVE;
        ST_ACTIVE: begin
          if (w_tc) begin
            w_finish = 1'b1;
            w_next   = ST_IDLE;
          end else begin
            w_pixel = 1'b1;
            w_inc   = 1'b1;
          end
        end
        default:   w_next = ST_IDLE;
      endcase
      if (w_accept) begin
        w_next  = ST_FETCH;
        w_load  = 1'b1;
        w_inc   = 1'b0;
        w_pixel = 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!nRESET) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Start latch, bank flip on every accepted start, one-CLK line-done pulse.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      r_start_pend <= 1'b0;
      r_bank       <= 1'b0;
      r_line_done  <= 1'b0;
    end else begin
      r_line_done <= w_finish;
      if (CE_PIX)          r_start_pend <= 1'b0;
      else if (LINE_START) r_start_pend <= 1'b1;
      if (w_accept) r_bank <= ~r_bank;
    end
  end

  // Palette output register: a pixel only while streaming, backdrop otherwise.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      r_pal       <= BACKDROP;
      r_pal_valid <= 1'b0;
    end else if (CE_PIX) begin
      if (w_pixel) begin
        r_pal       <= RD_DATA;
        r_pal_valid <= 1'b1;
      end else begin
        r_pal       <= BACKDROP;
        r_pal_valid <= 1'b0;
      end
    end
  end

  assign RD_ADDR   = w_addr;
  assign BANK      = r_bank;
  assign PAL_ADDR  = r_pal;
  assign PAL_VALID = r_pal_valid;
  assign LINE_DONE = r_line_done;

`ifdef LB_READ_CLEAR_EN
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;

  // Queue a backdrop write to the address whose data was just consumed.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
    end else begin
      r_wr_en <= w_pixel;
      if (w_pixel) r_wr_addr <= w_addr;
    end
  end

  // Gating with nRESET keeps a queued clear from landing on the reset edge.
  assign WR_EN   = r_wr_en & nRESET;
  assign WR_ADDR = r_wr_addr;
  assign WR_DATA = BACKDROP;
`else
  assign WR_EN   = 1'b0;
  assign WR_ADDR = '0;
  assign WR_DATA = BACKDROP;
`endif

endmodule

// File: tb/tb_lb_reader.sv
// tb_lb_reader: directed checks of lb_reader against a 1-CLK-latency RAM
// model preloaded with data = address. Pixel ticks are spaced two CLKs apart.
module tb_lb_reader;
  import neo_lb_pkg::*;

  localparam int LINE_LEN = 320;
  localparam int ADDR_W   = 9;

  logic              CLK        = 1'b0;
  logic              nRESET     = 1'b0;
  logic              CE_PIX     = 1'b0;
  logic              LINE_START = 1'b0;
  logic [ADDR_W-1:0] H_OFS      = '0;
  logic [ADDR_W-1:0] RD_ADDR;
  logic [11:0]       RD_DATA;
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [11:0]       WR_DATA;
  logic              BANK;
  logic [11:0]       PAL_ADDR;
  logic              PAL_VALID;
  logic              LINE_DONE;

  logic [11:0] mem [0:511];
  logic        reload = 1'b1;

  int   vectorCount = 0;
  int   missCount   = 0;
  int   doneSeen    = 0;
  int   validSeen   = 0;
  int   wrSeen      = 0;
  logic lastDone    = 1'b0;
  logic tickDone    = 1'b0;

  always #5 CLK = ~CLK;

  lb_reader #(
    .LINE_LEN (LINE_LEN),
    .ADDR_W   (ADDR_W)
  ) dut (
    .CLK        (CLK),
    .nRESET     (nRESET),
    .CE_PIX     (CE_PIX),
    .LINE_START (LINE_START),
    .H_OFS      (H_OFS),
    .RD_ADDR    (RD_ADDR),
    .RD_DATA    (RD_DATA),
    .WR_EN      (WR_EN),
    .WR_ADDR    (WR_ADDR),
    .WR_DATA    (WR_DATA),
    .BANK       (BANK),
    .PAL_ADDR   (PAL_ADDR),
    .PAL_VALID  (PAL_VALID),
    .LINE_DONE  (LINE_DONE)
  );

  // Line-buffer RAM: one-CLK read latency, clear-write port, bulk reload.
  always @(posedge CLK) begin
    RD_DATA <= mem[RD_ADDR];
    if (reload) begin
      for (int i = 0; i < 512; i++) mem[i] <= 12'(i);
    end else if (WR_EN) begin
      mem[WR_ADDR] <= WR_DATA;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectorCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One CLK with the given enable/start; pulse outputs are tallied after the edge.
  task automatic applyStimulus(input logic ce, input logic ls);
    @(negedge CLK);
    CE_PIX     = ce;
    LINE_START = ls;
    @(posedge CLK);
    #1;
    CE_PIX     = 1'b0;
    LINE_START = 1'b0;
    lastDone   = LINE_DONE;
    if (LINE_DONE) doneSeen++;
    if (WR_EN) wrSeen++;
    if (ce && PAL_VALID) validSeen++;
  endtask

  // One pixel tick followed by one idle CLK.
  task automatic pixTick(input logic ls);
    applyStimulus(1'b1, ls);
    tickDone = lastDone;
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic reloadMem();
    @(negedge CLK);
    reload = 1'b1;
    @(negedge CLK);
    reload = 1'b0;
  endtask

  // Pixel ticks for pixels first..first+count-1, checking each palette index.
  task automatic runPixels(input string tag, input int hofs, input int first, input int count);
    for (int n = first; n < first + count; n++) begin
      pixTick(1'b0);
      checkOutput(tag, 32'(PAL_ADDR), 32'((hofs + n) % 512));
    end
  endtask

  // Final tick of a full line: done pulse and backdrop.
  task automatic finishLine(input string tag);
    pixTick(1'b0);
    checkOutput({tag, "_done"}, 32'(tickDone), 32'd1);
    checkOutput({tag, "_backdrop"}, 32'(PAL_ADDR), 32'hFFF);
    checkOutput({tag, "_novalid"}, 32'(PAL_VALID), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;

    // Reset state.
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    reload = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkOutput("rst_pal", 32'(PAL_ADDR), 32'hFFF);
    checkOutput("rst_valid", 32'(PAL_VALID), 32'd0);
    checkOutput("rst_bank", 32'(BANK), 32'd0);
    checkOutput("rst_rdaddr", 32'(RD_ADDR), 32'd0);
    checkOutput("rst_done", 32'(LINE_DONE), 32'd0);
    checkOutput("rst_wren", 32'(WR_EN), 32'd0);
    checkOutput("rst_wraddr", 32'(WR_ADDR), 32'd0);
    checkOutput("rst_wrdata", 32'(WR_DATA), 32'hFFF);
    nRESET = 1'b1;

    // Pixel ticks in IDLE without a start do nothing.
    pixTick(1'b0);
    pixTick(1'b0);
    checkOutput("idle_valid", 32'(PAL_VALID), 32'd0);
    checkOutput("idle_bank", 32'(BANK), 32'd0);

    // Full line from offset 8.
    doneSeen  = 0;
    validSeen = 0;
    H_OFS = 9'd8;
    pixTick(1'b1);
    checkOutput("lineA_bank", 32'(BANK), 32'd1);
    checkOutput("lineA_fetch_addr", 32'(RD_ADDR), 32'd8);
    checkOutput("lineA_t0_valid", 32'(PAL_VALID), 32'd0);
    pixTick(1'b0);
    checkOutput("lineA_t1_pal", 32'(PAL_ADDR), 32'hFFF);
    checkOutput("lineA_t1_valid", 32'(PAL_VALID), 32'd0);
    runPixels("lineA_pix", 8, 0, LINE_LEN);
    finishLine("lineA");
    pixTick(1'b0);
    checkOutput("lineA_done_count", 32'(doneSeen), 32'd1);
    checkOutput("lineA_valid_count", 32'(validSeen), 32'(LINE_LEN));
    bad = 0;
    for (int a = 8; a < 8 + LINE_LEN; a++) begin
`ifdef LB_READ_CLEAR_EN
      if (mem[a] !== 12'hFFF) bad++;
`else
      if (mem[a] !== 12'(a)) bad++;
`endif
    end
    checkOutput("lineA_ram", 32'(bad), 32'd0);

    // Offset 500: the read address wraps from 511 to 0 mid-line.
    reloadMem();
    doneSeen = 0;
    H_OFS = 9'd500;
    pixTick(1'b1);
    checkOutput("wrap_bank", 32'(BANK), 32'd0);
    checkOutput("wrap_fetch_addr", 32'(RD_ADDR), 32'd500);
    pixTick(1'b0);
    for (int n = 0; n < LINE_LEN; n++) begin
      pixTick(1'b0);
      checkOutput("wrap_pix", 32'(PAL_ADDR), 32'((500 + n) % 512));
      checkOutput("wrap_addr", 32'(RD_ADDR), 32'((501 + n) % 512));
    end
    finishLine("wrap");
    checkOutput("wrap_done_count", 32'(doneSeen), 32'd1);

    // Restart at pixel 100: no done for the aborted line, new line from new offset.
    reloadMem();
    doneSeen = 0;
    H_OFS = 9'd20;
    pixTick(1'b1);
    pixTick(1'b0);
    runPixels("abortA_pix", 20, 0, 100);
    H_OFS = 9'd40;
    pixTick(1'b1);
    checkOutput("abort_bank", 32'(BANK), 32'd0);
    checkOutput("abort_nodone", 32'(tickDone), 32'd0);
    checkOutput("abort_addr", 32'(RD_ADDR), 32'd40);
    checkOutput("abort_pal", 32'(PAL_ADDR), 32'hFFF);
    checkOutput("abort_valid", 32'(PAL_VALID), 32'd0);
    pixTick(1'b0);
    runPixels("abortB_pix", 40, 0, LINE_LEN);
    finishLine("abortB");
    checkOutput("abort_done_count", 32'(doneSeen), 32'd1);

    // Pixel enable stalled for 5 extra CLKs mid-line.
    reloadMem();
    H_OFS = 9'd8;
    pixTick(1'b1);
    pixTick(1'b0);
    runPixels("stallA_pix", 8, 0, 10);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("stall_pal_hold", 32'(PAL_ADDR), 32'd17);
    checkOutput("stall_addr_hold", 32'(RD_ADDR), 32'd18);
    checkOutput("stall_valid_hold", 32'(PAL_VALID), 32'd1);
    runPixels("stallB_pix", 8, 10, LINE_LEN - 10);
    finishLine("stall");

    // Start without pixel enable is held, then taken on the next tick.
    reloadMem();
    H_OFS = 9'd100;
    applyStimulus(1'b0, 1'b1);
    checkOutput("pend_bank_wait", 32'(BANK), 32'd1);
    applyStimulus(1'b0, 1'b0);
    pixTick(1'b0);
    checkOutput("pend_bank_take", 32'(BANK), 32'd0);
    checkOutput("pend_addr", 32'(RD_ADDR), 32'd100);
    pixTick(1'b0);
    runPixels("pend_pix", 100, 0, LINE_LEN);

    // Start on the final tick: done pulses and the new line begins.
    H_OFS = 9'd200;
    pixTick(1'b1);
    checkOutput("coin_done", 32'(tickDone), 32'd1);
    checkOutput("coin_bank", 32'(BANK), 32'd1);
    checkOutput("coin_addr", 32'(RD_ADDR), 32'd200);
    checkOutput("coin_pal", 32'(PAL_ADDR), 32'hFFF);
    pixTick(1'b0);
    runPixels("coin_pix", 200, 0, 50);

    // Reset at pixel 50 abandons the line.
    nRESET = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("midrst_pal", 32'(PAL_ADDR), 32'hFFF);
    checkOutput("midrst_valid", 32'(PAL_VALID), 32'd0);
    checkOutput("midrst_bank", 32'(BANK), 32'd0);
    checkOutput("midrst_wren", 32'(WR_EN), 32'd0);
    checkOutput("midrst_addr", 32'(RD_ADDR), 32'd0);
    nRESET = 1'b1;
    pixTick(1'b0);
    pixTick(1'b0);
    checkOutput("midrst_idle_valid", 32'(PAL_VALID), 32'd0);
    checkOutput("midrst_idle_pal", 32'(PAL_ADDR), 32'hFFF);

`ifndef LB_READ_CLEAR_EN
    checkOutput("no_clear_writes", 32'(wrSeen), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
